// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch PC register and IF/ID pipeline register with fetch counter
// Optional address-error (AdEL) detection is enabled by defining FETCH_ADEL_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic [31:0]      NPC,
  input  logic [31:0]      InstrIn,
  output logic [31:0]      PC,
  output logic [IM_AW-1:0] IMAddr,
  output logic [31:0]      D_Instr,
  output logic [31:0]      D_PC,
  output logic             D_Valid,
  output logic [31:0]      FetchCount
`ifdef FETCH_ADEL_EN
  ,
  output logic             D_ExcAdEL
`endif
);

  typedef enum logic {
    BUBBLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t state;

  // Word index of (PC - IM_BASE); the borrow term covers a base that is not word aligned.
  assign IMAddr = PC[IM_AW+1:2] - IM_BASE[IM_AW+1:2]
                - IM_AW'(PC[1:0] < IM_BASE[1:0]);

  assign D_Valid = (state == RUN);

`ifdef FETCH_ADEL_EN
  localparam logic [31:0] IM_BYTES = 32'(4) << IM_AW;

  logic [31:0] pc_off;
  logic        adel;

  // Unsigned compare also catches PCs below IM_BASE, which wrap to large offsets.
  assign pc_off = PC - IM_BASE;
  assign adel   = (PC[1:0] != 2'b00) || (pc_off >= IM_BYTES);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BUBBLE;
      PC         <= RESET_PC;
      D_Instr    <= 32'h0;
      D_PC       <= 32'h0;
      FetchCount <= 32'h0;
`ifdef FETCH_ADEL_EN
      D_ExcAdEL  <= 1'b0;
`endif
    end else if (!Stall) begin
      state      <= RUN;
      PC         <= NPC;
      D_PC       <= PC;
      FetchCount <= FetchCount + 32'd1;
`ifdef FETCH_ADEL_EN
      D_Instr    <= adel ? 32'h0 : InstrIn;
      D_ExcAdEL  <= adel;
`else
      D_Instr    <= InstrIn;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven and scoreboard bench for fetch_stage
module tb_fetch_stage;

`ifdef FETCH_ADEL_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        Stall;
  logic [31:0] NPC;
  logic [31:0] InstrIn;
  logic [31:0] PC;
  logic [11:0] IMAddr;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic        D_Valid;
  logic [31:0] FetchCount;
`ifdef FETCH_ADEL_EN
  logic        D_ExcAdEL;
`endif

  fetch_stage #(
    .RESET_PC(32'h0000_3000),
    .IM_BASE (32'h0000_3000),
    .IM_AW   (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Stall     (Stall),
    .NPC       (NPC),
    .InstrIn   (InstrIn),
    .PC        (PC),
    .IMAddr    (IMAddr),
    .D_Instr   (D_Instr),
    .D_PC      (D_PC),
    .D_Valid   (D_Valid),
    .FetchCount(FetchCount)
`ifdef FETCH_ADEL_EN
    ,
    .D_ExcAdEL (D_ExcAdEL)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: a lui-style word tagged with its word index.
  always_comb InstrIn = 32'h3C01_0000 | {20'h0, IMAddr};

  function automatic logic [11:0] word_idx(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - 32'h0000_3000;
    return off[13:2];
  endfunction

  typedef struct {
    logic        rst;
    logic        stall;
    logic [31:0] npc;
    logic [31:0] pc;
    logic [31:0] dinstr;
    logic [31:0] dpc;
    logic        valid;
    logic [31:0] cnt;
    logic        adel;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dinstr;
    logic [31:0] dpc;
    logic        valid;
    logic [31:0] cnt;
    logic        adel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic [31:0] n, input logic [31:0] p,
                     input logic [31:0] di, input logic [31:0] dp, input logic v,
                     input logic [31:0] c, input logic a);
    vec_t t;
    t.rst = r; t.stall = s; t.npc = n; t.pc = p; t.dinstr = di; t.dpc = dp;
    t.valid = v; t.cnt = c; t.adel = a;
    vecs.push_back(t);
  endtask

  task automatic step(input logic r, input logic s, input logic [31:0] n, input exp_t e);
    @(negedge clk);
    reset = r;
    Stall = s;
    NPC   = n;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("PC", PC, e.pc);
    chk("IMAddr", {20'h0, IMAddr}, {20'h0, word_idx(e.pc)});
    chk("D_Instr", D_Instr, e.dinstr);
    chk("D_PC", D_PC, e.dpc);
    chk("D_Valid", {31'h0, D_Valid}, {31'h0, e.valid});
    chk("FetchCount", FetchCount, e.cnt);
`ifdef FETCH_ADEL_EN
    chk("D_ExcAdEL", {31'h0, D_ExcAdEL}, {31'h0, e.adel});
`endif
  endtask

  initial begin
    logic [31:0] m_pc, m_di, m_dp, m_cnt, n;
    logic        s;
    exp_t        e;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    Stall = 1'b0;
    NPC   = 32'h0;

    //  rst stall npc           pc            d_instr                        d_pc          v  cnt  adel
    add(1, 0, 32'h0000_3000, 32'h0000_3000, 32'h0,                         32'h0,         0, 0,  0);
    add(1, 1, 32'h0000_3000, 32'h0000_3000, 32'h0,                         32'h0,         0, 0,  0);
    add(0, 1, 32'h0000_3004, 32'h0000_3000, 32'h0,                         32'h0,         0, 0,  0);
    add(0, 0, 32'h0000_3004, 32'h0000_3004, 32'h3C01_0000,                 32'h0000_3000, 1, 1,  0);
    add(0, 0, 32'h0000_3008, 32'h0000_3008, 32'h3C01_0001,                 32'h0000_3004, 1, 2,  0);
    add(0, 0, 32'h0000_300C, 32'h0000_300C, 32'h3C01_0002,                 32'h0000_3008, 1, 3,  0);
    add(0, 0, 32'h0000_3100, 32'h0000_3100, 32'h3C01_0003,                 32'h0000_300C, 1, 4,  0);
    add(0, 0, 32'h0000_3104, 32'h0000_3104, 32'h3C01_0040,                 32'h0000_3100, 1, 5,  0);
    add(0, 0, 32'h0000_3010, 32'h0000_3010, 32'h3C01_0041,                 32'h0000_3104, 1, 6,  0);
    add(0, 1, 32'h0000_3014, 32'h0000_3010, 32'h3C01_0041,                 32'h0000_3104, 1, 6,  0);
    add(0, 1, 32'h0000_3200, 32'h0000_3010, 32'h3C01_0041,                 32'h0000_3104, 1, 6,  0);
    add(0, 1, 32'h0000_3300, 32'h0000_3010, 32'h3C01_0041,                 32'h0000_3104, 1, 6,  0);
    add(0, 0, 32'h0000_3014, 32'h0000_3014, 32'h3C01_0004,                 32'h0000_3010, 1, 7,  0);
    add(0, 0, 32'h0000_3018, 32'h0000_3018, 32'h3C01_0005,                 32'h0000_3014, 1, 8,  0);
    add(1, 1, 32'h0000_301C, 32'h0000_3000, 32'h0,                         32'h0,         0, 0,  0);
    add(0, 0, 32'h0000_3004, 32'h0000_3004, 32'h3C01_0000,                 32'h0000_3000, 1, 1,  0);
    add(0, 0, 32'h0000_7000, 32'h0000_7000, 32'h3C01_0001,                 32'h0000_3004, 1, 2,  0);
    add(0, 0, 32'h0000_3006, 32'h0000_3006, ADEL ? 32'h0 : 32'h3C01_0000,  32'h0000_7000, 1, 3,  ADEL);
    add(0, 0, 32'h0000_2FFC, 32'h0000_2FFC, ADEL ? 32'h0 : 32'h3C01_0001,  32'h0000_3006, 1, 4,  ADEL);
    add(0, 0, 32'h0000_3008, 32'h0000_3008, ADEL ? 32'h0 : 32'h3C01_0FFF,  32'h0000_2FFC, 1, 5,  ADEL);
    add(0, 0, 32'h0000_300C, 32'h0000_300C, 32'h3C01_0002,                 32'h0000_3008, 1, 6,  0);

    foreach (vecs[i]) begin
      e.pc = vecs[i].pc; e.dinstr = vecs[i].dinstr; e.dpc = vecs[i].dpc;
      e.valid = vecs[i].valid; e.cnt = vecs[i].cnt; e.adel = vecs[i].adel;
      step(vecs[i].rst, vecs[i].stall, vecs[i].npc, e);
    end

    // Random stall pattern over a sequential stream, tracked by a reference model.
    m_pc = 32'h0000_300C; m_di = 32'h3C01_0002; m_dp = 32'h0000_3008; m_cnt = 32'd6;
    for (int k = 0; k < 40; k++) begin
      s = ($urandom_range(0, 2) == 0);
      n = m_pc + 32'd4;
      if (!s) begin
        m_di  = 32'h3C01_0000 | {20'h0, word_idx(m_pc)};
        m_dp  = m_pc;
        m_pc  = n;
        m_cnt = m_cnt + 32'd1;
      end
      e.pc = m_pc; e.dinstr = m_di; e.dpc = m_dp; e.valid = 1'b1; e.cnt = m_cnt; e.adel = 1'b0;
      step(1'b0, s, n, e);
    end

    // Reset taken mid-stall after a long run, then a stalled bubble, then the first fetch.
    e.pc = 32'h0000_3000; e.dinstr = 32'h0; e.dpc = 32'h0; e.valid = 1'b0; e.cnt = 32'd0; e.adel = 1'b0;
    step(1'b1, 1'b1, 32'h0000_3040, e);
    step(1'b0, 1'b1, 32'h0000_3040, e);
    e.pc = 32'h0000_3040; e.dinstr = 32'h3C01_0000; e.dpc = 32'h0000_3000; e.valid = 1'b1; e.cnt = 32'd1;
    step(1'b0, 1'b0, 32'h0000_3040, e);

    if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Sequential counterpart of the combinational next-PC logic.
- Holds the architectural fetch PC and supplies it to next-PC logic and instruction memory.
- Latches the fetched instruction and its PC into the IF/ID pipeline register; these feed back to next-PC logic as the decode-stage instruction and PC.
- Part of the 5-stage MIPS pipeline, delayed-branch semantics: no flush on taken branch/jump.

Parameters:
- RESET_PC, 32'h00003000, fetch PC after reset.
- IM_BASE, 32'h00003000, byte address of instruction memory word 0.
- IM_AW, 12, instruction memory word-address width (IM holds 2^IM_AW words).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard stall from hazard unit; freezes PC, IF/ID register and counter.
- NPC  input  32  next fetch address from next-PC logic.
- InstrIn  input  32  instruction memory read data for IMAddr (combinational IM, same cycle).
- PC  output  32  current fetch PC; to next-PC logic PC input.
- IMAddr  output  IM_AW  word index into IM = (PC - IM_BASE) >> 2, truncated to IM_AW bits.
- D_Instr  output  32  IF/ID instruction.
- D_PC  output  32  IF/ID PC (the PC at which D_Instr was fetched).
- D_Valid  output  1  IF/ID holds a real fetched instruction (0 = reset bubble).
- FetchCount  output  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset values, when reset=1 at a rising edge:
  - PC=RESET_PC, D_Instr=32'h0 (nop), D_PC=32'h0, D_Valid=0, FetchCount=0.
  - reset has priority over Stall.
- Run cycle, reset=0 and Stall=0 at an edge:
  - PC<=NPC
  - D_Instr<=InstrIn
  - D_PC<=PC (old value)
  - D_Valid<=1
  - FetchCount<=FetchCount+1
- Stall cycle, reset=0 and Stall=1: PC, D_Instr, D_PC, D_Valid and FetchCount all hold.
  - Next-PC logic sees a stable PC; the same IM word is re-presented.
- Latency: instruction at PC appears on D_Instr/D_PC one unstalled edge after PC is presented.
- Sequence states, implicit in D_Valid:
  - BUBBLE (after reset, D_Valid=0) -> RUN on the first unstalled edge.
  - RUN stays RUN until reset.
  - Stall in BUBBLE keeps BUBBLE.
- Delayed branch:
  - The delay-slot instruction is latched normally.
  - Branch target arrives via NPC; the block performs no squash.
- Arithmetic:
  - IMAddr = PC - IM_BASE (32-bit, mod 2^32), bits [IM_AW+1:2].
  - Out-of-range PCs alias silently (without optional feature).
- Alignment: NPC is loaded verbatim; no forced alignment.
- FetchCount wraps 32'hFFFFFFFF -> 0 with no flag.
- Reset mid-stall: reset wins and takes effect the same edge.
- Stall deasserting: the update occurs on the first edge with Stall=0.
- PC, IMAddr and all D_* outputs are registered or derived only from registers; there is no combinational path from Stall/NPC to outputs.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- When defined:
  - Adds output D_ExcAdEL (1 bit, reset 0).
  - On an unstalled edge, if PC[1:0]!=0 or PC outside [IM_BASE, IM_BASE + 4*2^IM_AW):
    - D_Instr<=32'h0, D_ExcAdEL<=1, D_PC<=PC, D_Valid<=1, FetchCount increments.
  - Otherwise D_ExcAdEL<=0.
  - Holds under Stall.
- When undefined:
  - No D_ExcAdEL port.
  - InstrIn is always latched regardless of PC value.

Test Plan:
- Reset then Stall=0, NPC=PC+4, IM returns 0x3C01xxxx-style words:
  - after edge 1: PC=0x3004, D_PC=0x3000, D_Valid=1, FetchCount=1.
  - IMAddr for PC 0x3004 = 1.
- Stall=1 for 3 cycles mid-run at PC=0x3010:
  - PC, D_Instr, D_PC, FetchCount unchanged all 3 cycles.
  - on release: PC=NPC, D_PC=0x3010.
- Branch at 0x3008, NPC drives 0x3100 while delay slot is at 0x300C:
  - D_PC sequence 0x3008, 0x300C, 0x3100; no squash.
- reset=1 asserted together with Stall=1 while FetchCount=57:
  - next edge: PC=0x3000, FetchCount=0, D_Valid=0, D_Instr=0.
- FetchCount preloaded to 32'hFFFFFFFF (via run), one unstalled edge:
  - FetchCount=0.
- With FETCH_ADEL_EN, NPC=0x3006 then 0x2FFC:
  - each yields D_ExcAdEL=1, D_Instr=0, D_PC=0x3006 then 0x2FFC.
  - aligned in-range PC clears D_ExcAdEL.
